// File: rtl/apb_mem_pkg.sv
// Shared types and default parameter values for the parametrised APB memory slave.
// Contents: transfer state enum, default widths/depth.
package apb_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 256;
  localparam int unsigned WAIT_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    STROBE,
    DONE
  } state_t;

endpackage

// File: rtl/apb_wait_counter.sv
// Wait-state down-counter for the APB memory slave.
// Ports: clk, rst (async active-high), load/load_val (capture count on setup),
//        dec (count down while waiting), zero_c (combinational count==0 flag).
module apb_wait_counter #(
  parameter int unsigned WAIT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  input  logic              dec,
  output logic              zero_c
);

  logic [WAIT_W-1:0] count;

  // Saturates at zero so the count never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - WAIT_W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/apb_mem_slave_p.sv
// Parametrised APB slave bridging to a single-port memory bus with programmable,
// per-transfer wait states and transfer abort.
// Ports: clk, rst (async active-high); APB side sel/enable/write/addr/wdata,
//        wait_cycles (sampled in setup), rdata/ready/slverr; memory side
//        wren/rden (one-cycle strobes), mem_addr/mem_wdata, mem_rdata.
// Option: define APB_MEM_SLAVE_SLVERR_EN to answer addr >= DEPTH with slverr
//         and no strobe; otherwise such addresses alias onto addr mod DEPTH.
module apb_mem_slave_p
  import apb_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned WAIT_W = WAIT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sel,
  input  logic                     enable,
  input  logic                     write,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [WAIT_W-1:0]        wait_cycles,
  output logic [DATA_W-1:0]        rdata,
  output logic                     ready,
  output logic                     slverr,
  output logic                     wren,
  output logic                     rden,
  output logic [$clog2(DEPTH)-1:0] mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int unsigned MEM_AW = $clog2(DEPTH);

  state_t state;
  logic   cap_write;
  logic   cap_err;
  logic   setup_c;
  logic   cnt_dec_c;
  logic   cnt_zero_c;

  assign setup_c   = (state == IDLE) && sel && !enable;
  assign cnt_dec_c = (state == WAIT) && sel;

  apb_wait_counter #(.WAIT_W(WAIT_W)) u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (setup_c),
    .load_val (wait_cycles),
    .dec      (cnt_dec_c),
    .zero_c   (cnt_zero_c)
  );

`ifdef APB_MEM_SLAVE_SLVERR_EN
  logic addr_oor_c;

  // Extra top bit keeps the compare exact when DEPTH == 2**ADDR_W.
  assign addr_oor_c = ({1'b0, addr} >= (ADDR_W+1)'(DEPTH));

  // Out-of-range flag captured alongside the rest of the setup phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_err <= 1'b0;
    end else if (setup_c) begin
      cap_err <= addr_oor_c;
    end
  end
`else
  logic unused_addr;

  // Only the low address bits reach memory; higher bits alias.
  assign cap_err     = 1'b0;
  assign unused_addr = ^addr;
`endif

  // Transfer sequencer: setup capture, wait, strobe, hold ready until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cap_write <= 1'b0;
      rdata     <= '0;
      ready     <= 1'b0;
      slverr    <= 1'b0;
      wren      <= 1'b0;
      rden      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      wren <= 1'b0;
      rden <= 1'b0;
      case (state)
        IDLE: begin
          if (setup_c) begin
            cap_write <= write;
            mem_addr  <= addr[MEM_AW-1:0];
            mem_wdata <= wdata;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (!sel) begin
            state <= IDLE;
          end else if (cnt_zero_c) begin
            wren  <= cap_write && !cap_err;
            rden  <= !cap_write && !cap_err;
            state <= STROBE;
          end
        end
        STROBE: begin
          if (!sel) begin
            state <= IDLE;
          end else begin
            ready  <= 1'b1;
            slverr <= cap_err;
            if (!cap_write) begin
              rdata <= cap_err ? '0 : mem_rdata;
            end
            state <= DONE;
          end
        end
        DONE: begin
          // Aborted or accepted: either way the response is withdrawn.
          if (!sel || (enable && ready)) begin
            ready  <= 1'b0;
            slverr <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_mem_slave_p.sv
module tb_apb_mem_slave_p;
  import apb_mem_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic       enable = 1'b0;
  logic       write = 1'b0;
  logic [7:0] addr = '0;
  logic [7:0] wdata = '0;
  logic [3:0] wait_cycles = '0;
  logic [7:0] rdata;
  logic       ready;
  logic       slverr;
  logic       wren;
  logic       rden;
  logic [6:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  apb_mem_slave_p #(
    .ADDR_W (8),
    .DATA_W (8),
    .DEPTH  (128),
    .WAIT_W (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sel         (sel),
    .enable      (enable),
    .write       (write),
    .addr        (addr),
    .wdata       (wdata),
    .wait_cycles (wait_cycles),
    .rdata       (rdata),
    .ready       (ready),
    .slverr      (slverr),
    .wren        (wren),
    .rden        (rden),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  // Cycle n is the interval following the n-th rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: write on wren, read data presented combinationally.
  logic [7:0] mem [128];
  initial for (int i = 0; i < 128; i++) mem[i] = 8'h00;
  always @(posedge clk) if (wren) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  // Strobe monitor, sampled on the falling edge.
  int         n_wren = 0, n_rden = 0, n_both = 0;
  int         wren_at = -1, rden_at = -1;
  logic [6:0] strb_addr;
  logic [7:0] strb_data;
  always @(negedge clk) begin
    if (wren) begin n_wren++; wren_at = cyc; strb_addr = mem_addr; strb_data = mem_wdata; end
    if (rden) begin n_rden++; rden_at = cyc; strb_addr = mem_addr; end
    if (wren && rden) n_both++;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One complete APB transfer starting in the current cycle, with checks.
  task automatic run_xfer(input string tag, input logic wr, input logic [7:0] a,
                          input logic [7:0] d, input logic [3:0] w,
                          input logic [7:0] exp_rd, input logic exp_err,
                          input logic exp_strb, input logic [6:0] exp_maddr,
                          output int t0, output int done_at);
    int         nw0, nr0, rdy_at;
    logic [7:0] rd;
    logic       err;
    nw0 = n_wren; nr0 = n_rden; rdy_at = -1; rd = '0; err = 1'b0;
    sel = 1'b1; enable = 1'b0; write = wr; addr = a; wdata = d; wait_cycles = w;
    t0 = cyc;
    @(posedge clk); #1;
    // Access phase: scramble inputs that must already be captured.
    enable = 1'b1; addr = ~a; wdata = ~d; wait_cycles = ~w;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) begin rdy_at = cyc; rd = rdata; err = slverr; break; end
    end
    @(posedge clk); #1;
    sel = 1'b0; enable = 1'b0;
    done_at = rdy_at;
    check({tag, " ready offset"}, 32'(rdy_at - t0), 32'(w) + 32'd3);
    check({tag, " wren count"}, 32'(n_wren - nw0), 32'(wr && exp_strb));
    check({tag, " rden count"}, 32'(n_rden - nr0), 32'(!wr && exp_strb));
    if (exp_strb) begin
      check({tag, " strobe offset"}, 32'((wr ? wren_at : rden_at) - t0), 32'(w) + 32'd2);
      check({tag, " mem_addr"}, 32'(strb_addr), 32'(exp_maddr));
      if (wr) check({tag, " mem_wdata"}, 32'(strb_data), 32'(d));
    end
    if (!wr) check({tag, " rdata"}, 32'(rd), 32'(exp_rd));
    check({tag, " slverr"}, 32'(err), 32'(exp_err));
  endtask

  int t0, t0b, done1, done2, nw0, nr0;

  initial begin
    // Reset state
    @(negedge clk);
    check("reset outputs", 32'({ready, slverr, wren, rden, rdata, mem_addr, mem_wdata}), 32'd0);
    check("reset state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;
    @(posedge clk); #1;

    // Write W=5, then read W=0 of the same location
    run_xfer("wr w5", 1'b1, 8'h10, 8'hA5, 4'd5, 8'h00, 1'b0, 1'b1, 7'h10, t0, done1);
    repeat (2) @(posedge clk); #1;
    run_xfer("rd w0", 1'b0, 8'h10, 8'h00, 4'd0, 8'hA5, 1'b0, 1'b1, 7'h10, t0, done1);
    repeat (2) @(posedge clk); #1;

    // Back-to-back write then read, no idle cycle between
    run_xfer("b2b wr", 1'b1, 8'h2B, 8'h3C, 4'd1, 8'h00, 1'b0, 1'b1, 7'h2B, t0, done1);
    run_xfer("b2b rd", 1'b0, 8'h2B, 8'h00, 4'd2, 8'h3C, 1'b0, 1'b1, 7'h2B, t0b, done2);
    check("b2b setup follows completion", 32'(t0b - done1), 32'd1);

    // Maximum wait count
    repeat (2) @(posedge clk); #1;
    run_xfer("rd w15", 1'b0, 8'h10, 8'h00, 4'd15, 8'hA5, 1'b0, 1'b1, 7'h10, t0, done1);

    // Abort: sel dropped at T0+3 of a W=5 write
    repeat (2) @(posedge clk); #1;
    nw0 = n_wren; nr0 = n_rden;
    sel = 1'b1; enable = 1'b0; write = 1'b1; addr = 8'h33; wdata = 8'h5A; wait_cycles = 4'd5;
    t0 = cyc;
    @(posedge clk); #1; enable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; sel = 1'b0; enable = 1'b0;
    @(negedge clk);
    check("abort sel drop cycle", 32'(cyc - t0), 32'd3);
    @(negedge clk);
    check("abort idle at T0+4", 32'(dut.state), 32'(IDLE));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ready) check("abort ready", 32'(ready), 32'd0);
    end
    check("abort no strobe", 32'((n_wren - nw0) + (n_rden - nr0)), 32'd0);
    check("abort mem untouched", 32'(mem[7'h33]), 32'd0);

    // Reset pulsed at T0+4 of a W=3 read
    @(posedge clk); #1;
    nw0 = n_wren; nr0 = n_rden;
    sel = 1'b1; enable = 1'b0; write = 1'b0; addr = 8'h10; wait_cycles = 4'd3;
    t0 = cyc;
    @(posedge clk); #1; enable = 1'b1;
    repeat (3) @(posedge clk);
    #2; rst = 1'b1; #1;
    check("reset mid cycle", 32'(cyc - t0), 32'd4);
    check("reset async clear", 32'({ready, slverr, wren, rden, rdata, mem_addr, mem_wdata}), 32'd0);
    @(negedge clk); rst = 1'b0;
    // sel+enable without a setup phase must be ignored
    repeat (3) @(negedge clk);
    sel = 1'b0; enable = 1'b0;
    repeat (4) @(negedge clk);
    check("reset no strobe", 32'((n_wren - nw0) + (n_rden - nr0)), 32'd0);
    check("reset no ready", 32'(ready), 32'd0);
    @(posedge clk); #1;
    run_xfer("post-reset rd", 1'b0, 8'h10, 8'h00, 4'd3, 8'hA5, 1'b0, 1'b1, 7'h10, t0, done1);

    // Out-of-range address (DEPTH=128)
    repeat (2) @(posedge clk); #1;
`ifdef APB_MEM_SLAVE_SLVERR_EN
    run_xfer("oor wr", 1'b1, 8'hC0, 8'h77, 4'd2, 8'h00, 1'b1, 1'b0, 7'h40, t0, done1);
    run_xfer("oor rd", 1'b0, 8'hC0, 8'h00, 4'd1, 8'h00, 1'b1, 1'b0, 7'h40, t0, done1);
    check("oor mem untouched", 32'(mem[7'h40]), 32'd0);
`else
    run_xfer("alias wr", 1'b1, 8'hC0, 8'h77, 4'd2, 8'h00, 1'b0, 1'b1, 7'h40, t0, done1);
    run_xfer("alias rd", 1'b0, 8'hC0, 8'h00, 4'd1, 8'h77, 1'b0, 1'b1, 7'h40, t0, done1);
    check("alias mem write", 32'(mem[7'h40]), 32'h77);
`endif

    check("strobes exclusive", 32'(n_both), 32'd0);
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
